// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch front end between the instruction memory
// and decode. Holds the PC, issues one read per cycle into a memory with a
// 1-cycle registered read latency, buffers returned words (tagged with their
// PC) in a small FIFO and hands them to decode over valid/ready. Supports
// start, redirect (flushing wrong-path fetches) and halt with drain.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start                 pulse: IDLE/HALTED -> RUN, fetch from current pc
//   halt_req              pulse: stop issuing, drain, then HALTED
//   redirect              load redirect_target into pc, flush buffered/in-flight
//   redirect_target       new pc
//   imem_address          memory read address (the pc register)
//   imem_instruction      memory data for the address of the previous cycle
//   out_valid/out_ready   decode handshake on the FIFO head
//   out_instruction       FIFO head instruction
//   out_pc                pc the head was fetched from
//   halted                high in HALTED
module fetch_sequencer #(
   parameter int unsigned ADDR_WIDTH  = 12,
   parameter int unsigned INSTR_WIDTH = 19,
   parameter int unsigned RESET_PC    = 0,
   parameter int unsigned FIFO_DEPTH  = 3
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   halt_req,
   input  logic                   redirect,
   input  logic [ADDR_WIDTH-1:0]  redirect_target,
   output logic [ADDR_WIDTH-1:0]  imem_address,
   input  logic [INSTR_WIDTH-1:0] imem_instruction,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [INSTR_WIDTH-1:0] out_instruction,
   output logic [ADDR_WIDTH-1:0]  out_pc,
   output logic                   halted
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_HALTED
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
   logic                    inflight_q, inflight_d;
   logic [ADDR_WIDTH-1:0]   inflight_pc_q, inflight_pc_d;
   logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]           count_q, count_d;
   logic [INSTR_WIDTH-1:0]  fifo_instr_q [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0]   fifo_pc_q    [FIFO_DEPTH];

   logic                    issue;
   logic                    push;
   logic                    pop;
   logic [CW:0]             occupancy;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign imem_address    = pc_q;
   assign out_valid       = (count_q != '0);
   assign out_instruction = fifo_instr_q[rd_ptr_q];
   assign out_pc          = fifo_pc_q[rd_ptr_q];
   assign halted          = (state_q == S_HALTED);

   // Buffered plus in-flight entries; one bit wider so full+inflight cannot wrap.
   assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};

   // Reserving a slot for the in-flight word guarantees the push always fits.
   assign issue = (state_q == S_RUN) && !halt_req && !redirect &&
                  (occupancy < (CW + 1)'(FIFO_DEPTH));
   assign push  = inflight_q && !redirect;
   assign pop   = out_valid && out_ready;

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (start && !halt_req) state_d = S_RUN;
         S_RUN:    if (halt_req)           state_d = S_DRAIN;
         S_DRAIN:  if ((count_q == '0) && !inflight_q) state_d = S_HALTED;
         S_HALTED: if (start && !halt_req) state_d = S_RUN;
         default:  state_d = S_IDLE;
      endcase
   end

   // PC, in-flight tracking and FIFO pointer next-state.
   always_comb begin
      pc_d          = pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;

      if (issue) begin
         inflight_d    = 1'b1;
         inflight_pc_d = pc_q;
         pc_d          = pc_q + ADDR_WIDTH'(1);
      end

      if (redirect) begin
         // A same-cycle pop is still consumed by decode; flushing simply
         // discards everything else.
         pc_d     = redirect_target;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (!push && pop) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= S_IDLE;
         pc_q          <= ADDR_WIDTH'(RESET_PC);
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
      end
   end

   // Storage is cleared on reset so the head outputs are never X.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            fifo_instr_q[i] <= '0;
            fifo_pc_q[i]    <= '0;
         end
      end else if (push) begin
         fifo_instr_q[wr_ptr_q] <= imem_instruction;
         fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
      end
   end

   overflow_chk : assert property (@(posedge clock) disable iff (reset)
      !(push && !pop && (count_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

   logic        clock;
   logic        reset;
   logic        start;
   logic        halt_req;
   logic        redirect;
   logic [11:0] redirect_target;
   logic [11:0] imem_address;
   logic [18:0] imem_instruction;
   logic        out_valid;
   logic        out_ready;
   logic [18:0] out_instruction;
   logic [11:0] out_pc;
   logic        halted;

   int checks;
   int failures;

   logic [18:0] mem [0:4095];

   fetch_sequencer #(
      .ADDR_WIDTH (12),
      .INSTR_WIDTH(19),
      .RESET_PC   (0),
      .FIFO_DEPTH (3)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .start           (start),
      .halt_req        (halt_req),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .imem_address    (imem_address),
      .imem_instruction(imem_instruction),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_instruction (out_instruction),
      .out_pc          (out_pc),
      .halted          (halted)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Registered-read instruction memory.
   always @(posedge clock) imem_instruction <= mem[imem_address];

   initial begin
      #200000;
      $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_head(input string tag, input int pc, input int instr);
      chk({tag, "_valid"}, 32'(out_valid), 1);
      chk({tag, "_pc"}, 32'(out_pc), pc);
      chk({tag, "_instr"}, 32'(out_instruction), instr);
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; halt_req = 1'b0; redirect = 1'b0; out_ready = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int prog [4];
      prog = '{25, 23, 20, 12};
      checks = 0;
      failures = 0;
      reset = 1'b1; start = 1'b0; halt_req = 1'b0; redirect = 1'b0;
      redirect_target = '0; out_ready = 1'b0;
      for (int i = 0; i < 4096; i++) mem[i] = 19'(1000 + i);
      mem[0] = 19'd25; mem[1] = 19'd23; mem[2] = 19'd20; mem[3] = 19'd12;
      mem[100] = 19'd30; mem[4094] = 19'd7; mem[4095] = 19'd8;

      // Reset state.
      tick(); tick();
      reset = 1'b0;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_addr", 32'(imem_address), 0);
      chk("rst_instr", 32'(out_instruction), 0);
      chk("rst_pc", 32'(out_pc), 0);

      // Streaming, ready held high.
      do_reset();
      out_ready = 1'b1; start = 1'b1;
      tick(); start = 1'b0;                // E0
      chk("t1_e0_valid", 32'(out_valid), 0);
      chk("t1_e0_addr", 32'(imem_address), 0);
      tick();                              // E1
      chk("t1_e1_valid", 32'(out_valid), 0);
      chk("t1_e1_addr", 32'(imem_address), 1);
      tick();                              // E2
      for (int k = 0; k < 4; k++) begin
         chk_head("t1_stream", k, prog[k]);
         tick();
      end

      // Backpressure after the first accept.
      do_reset();
      out_ready = 1'b1; start = 1'b1;
      tick(); start = 1'b0;
      tick(); tick();                      // E2
      chk_head("t2_first", 0, 25);
      tick();                              // E3
      chk_head("t2_second", 1, 23);
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk_head("t2_hold", 1, 23);
         chk("t2_hold_addr", 32'(imem_address), 4);
      end
      out_ready = 1'b1;
      tick(); chk_head("t2_resume2", 2, 20);
      tick(); chk_head("t2_resume3", 3, 12);
      tick(); chk_head("t2_resume4", 4, 1004);

      // Redirect flushes buffered and in-flight wrong-path fetches.
      do_reset();
      out_ready = 1'b1; start = 1'b1;
      tick(); start = 1'b0;
      tick(); tick(); tick(); tick(); tick();  // E5
      chk_head("t3_pre", 3, 12);
      out_ready = 1'b0;
      tick();                              // E6: 3,4 buffered, 5 in flight
      chk_head("t3_held", 3, 12);
      chk("t3_held_addr", 32'(imem_address), 6);
      redirect = 1'b1; redirect_target = 12'd100;
      tick();                              // E7 redirect edge
      redirect = 1'b0; out_ready = 1'b1;
      chk("t3_flush_valid", 32'(out_valid), 0);
      chk("t3_flush_addr", 32'(imem_address), 100);
      tick();
      chk("t3_gap_valid", 32'(out_valid), 0);
      chk("t3_gap_addr", 32'(imem_address), 101);
      tick();
      chk_head("t3_target", 100, 30);

      // Redirect while idle, then wrap past the top of the address space.
      do_reset();
      redirect = 1'b1; redirect_target = 12'd4094;
      tick();
      redirect = 1'b0;
      chk("t4_idle_addr", 32'(imem_address), 4094);
      chk("t4_idle_valid", 32'(out_valid), 0);
      out_ready = 1'b1; start = 1'b1;
      tick(); start = 1'b0;
      tick(); tick();
      chk_head("t4_w0", 4094, 7);
      tick(); chk_head("t4_w1", 4095, 8);
      tick(); chk_head("t4_w2", 0, 25);

      // Halt with two entries buffered, then resume.
      do_reset();
      out_ready = 1'b0; start = 1'b1;
      tick(); start = 1'b0;                // E0
      tick(); tick();                      // E2
      halt_req = 1'b1;
      tick();                              // E3
      halt_req = 1'b0;
      chk_head("t5_buf0", 0, 25);
      chk("t5_addr_e3", 32'(imem_address), 2);
      chk("t5_halted_e3", 32'(halted), 0);
      out_ready = 1'b1;
      tick();
      chk_head("t5_buf1", 1, 23);
      chk("t5_addr_e4", 32'(imem_address), 2);
      tick();
      chk("t5_empty_valid", 32'(out_valid), 0);
      chk("t5_empty_halted", 32'(halted), 0);
      tick();
      chk("t5_halted", 32'(halted), 1);
      chk("t5_halted_addr", 32'(imem_address), 2);
      tick();
      chk("t5_still_halted", 32'(halted), 1);
      chk("t5_no_issue_valid", 32'(out_valid), 0);
      start = 1'b1;
      tick(); start = 1'b0;
      chk("t5_resume_halted", 32'(halted), 0);
      tick(); tick();
      chk_head("t5_resume", 2, 20);

      // Reset mid-stream.
      do_reset();
      out_ready = 1'b1; start = 1'b1;
      tick(); start = 1'b0;
      tick(); tick(); tick();
      chk("t6_pre_valid", 32'(out_valid), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_valid", 32'(out_valid), 0);
      chk("t6_halted", 32'(halted), 0);
      chk("t6_addr", 32'(imem_address), 0);
      chk("t6_pc", 32'(out_pc), 0);
      chk("t6_instr", 32'(out_instruction), 0);
      tick(); tick();
      chk("t6_idle_valid", 32'(out_valid), 0);
      chk("t6_idle_addr", 32'(imem_address), 0);
      start = 1'b1;
      tick(); start = 1'b0;
      tick(); tick();
      chk_head("t6_refetch", 0, 25);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
